// File: rtl/pipe_addn.sv
// Pipelined N-bit adder/subtractor: the carry ripples through one K-bit chunk per
// stage, and the not-yet-added operand chunks travel alongside in skew registers.
module pipe_addn #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int S = N / K;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. All stages advance together on en; an empty slot (in_valid=0) still
  // moves down the pipe, and a presented result holds until out_ready.
  logic         en;
  logic [N-1:0] b_eff;

  logic [S-1:0][N-1:0] x_q;  // result bits below the carry front, operand a above it
  logic [S-1:0][N-1:0] y_q;  // effective operand b (inverted when subtracting)
  logic [S-1:0]        c_q;
  logic [S-1:0]        v_q;
  logic [S-1:0]        am_q; // sign of operand a, kept for the overflow flag

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;

  for (genvar i = 0; i < S; i++) begin : g_stage
    logic [N-1:0] sx;
    logic [N-1:0] sy;
    logic         sc;
    logic         sv;
    logic         sa;
    logic [K:0]   csum;
    logic [N-1:0] x_d;
    logic [N-1:0] x_r;
    logic [N-1:0] y_r;
    logic         c_r;
    logic         v_r;
    logic         a_r;

    if (i == 0) begin : g_first
      // Subtraction is a + ~b + 1, so the stage-0 carry is forced high.
      assign sx = a;
      assign sy = b_eff;
      assign sc = sub | cin;
      assign sv = in_valid;
      assign sa = a[N-1];
    end else begin : g_next
      assign sx = x_q[i-1];
      assign sy = y_q[i-1];
      assign sc = c_q[i-1];
      assign sv = v_q[i-1];
      assign sa = am_q[i-1];
    end

    assign csum = {1'b0, sx[i*K +: K]} + {1'b0, sy[i*K +: K]} + {{K{1'b0}}, sc};

    always_comb begin
      x_d             = sx;
      x_d[i*K +: K]   = csum[K-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_r <= '0;
        y_r <= '0;
        c_r <= 1'b0;
        v_r <= 1'b0;
        a_r <= 1'b0;
      end else if (en) begin
        x_r <= x_d;
        y_r <= sy;
        c_r <= csum[K];
        v_r <= sv;
        a_r <= sa;
      end
    end

    assign x_q[i]  = x_r;
    assign y_q[i]  = y_r;
    assign c_q[i]  = c_r;
    assign v_q[i]  = v_r;
    assign am_q[i] = a_r;
  end

  assign out       = x_q[S-1];
  assign cout      = c_q[S-1];
  assign out_valid = v_q[S-1];
  assign ovf       = (am_q[S-1] == y_q[S-1][N-1]) & (out[N-1] != am_q[S-1]);

  // Only the sign of the effective b is needed once the last chunk is added.
  logic unused_y;
  assign unused_y = ^y_q[S-1][N-2:0];

endmodule

// File: tb/tb_pipe_addn.sv
// Bench for pipe_addn: three instances (16/4, 32/8, 8/8) driven by directed and
// random vectors, with a per-instance expected queue checked by one monitor.
module tb_pipe_addn;
  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  localparam int WID [3] = '{16, 32, 8};
  localparam int LAT [3] = '{4, 4, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT wiring ----------------
  logic [31:0] da [3];
  logic [31:0] db [3];
  logic        dcin [3];
  logic        dsub [3];
  logic        dvin [3];
  logic        dordy [3];
  logic        ordy [3];
  logic [31:0] mo [3];
  logic        mco [3];
  logic        mov [3];
  logic        mvld [3];
  logic        mrdy [3];
  logic [15:0] o16;
  logic [31:0] o32;
  logic [7:0]  o8;

  logic pat_on = 1'b0;
  logic pat_val = 1'b1;
  int   pcnt = 0;

  // out_ready pattern 1,0,0,1,0,0,... for the stall test
  always @(negedge clk) begin
    pat_val = (pcnt % 3 == 0);
    pcnt++;
  end

  assign ordy[0] = pat_on ? pat_val : dordy[0];
  assign ordy[1] = dordy[1];
  assign ordy[2] = dordy[2];
  assign mo[0]   = {16'b0, o16};
  assign mo[1]   = o32;
  assign mo[2]   = {24'b0, o8};

  pipe_addn #(.N(16), .K(4)) u16 (
    .clk(clk), .rst_n(rst_n), .a(da[0][15:0]), .b(db[0][15:0]), .cin(dcin[0]),
    .sub(dsub[0]), .in_valid(dvin[0]), .in_ready(mrdy[0]), .out(o16),
    .cout(mco[0]), .ovf(mov[0]), .out_valid(mvld[0]), .out_ready(ordy[0])
  );

  pipe_addn #(.N(32), .K(8)) u32 (
    .clk(clk), .rst_n(rst_n), .a(da[1]), .b(db[1]), .cin(dcin[1]),
    .sub(dsub[1]), .in_valid(dvin[1]), .in_ready(mrdy[1]), .out(o32),
    .cout(mco[1]), .ovf(mov[1]), .out_valid(mvld[1]), .out_ready(ordy[1])
  );

  pipe_addn #(.N(8), .K(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(da[2][7:0]), .b(db[2][7:0]), .cin(dcin[2]),
    .sub(dsub[2]), .in_valid(dvin[2]), .in_ready(mrdy[2]), .out(o8),
    .cout(mco[2]), .ovf(mov[2]), .out_valid(mvld[2]), .out_ready(ordy[2])
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q [3][$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [33:0] ex(input logic ov, input logic co, input logic [31:0] r);
    return {ov, co, r};
  endfunction

  // Arithmetic reference: full-width sum of a and the effective b.
  function automatic logic [33:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] s;
    logic [31:0] m;
    logic [31:0] be;
    logic        ov;
    m  = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    be = (sub ? ~b : b) & m;
    s  = {1'b0, a & m} + {1'b0, be} + {32'b0, sub | cin};
    ov = (a[n-1] == be[n-1]) && (s[n-1] != a[n-1]);
    return {ov, s[n], s[31:0] & m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [33:0] e, input bit lat);
    exp_t t;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      da[i] = a; db[i] = b; dcin[i] = cin; dsub[i] = sub; dvin[i] = 1'b1;
      #1;
      if (mrdy[i] && rst_n) begin
        t.res = e[31:0]; t.co = e[32]; t.ov = e[33]; t.acc = cyc; t.lat = lat;
        exp_q[i].push_back(t);
        return;
      end
    end
    check($sformatf("d%0d_issue_timeout", i), 64'(mrdy[i]), 64'd1);
  endtask

  task automatic issue_rand(input int i, input bit lat);
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    a = $urandom; b = $urandom;
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    issue(i, a, b, cin, sub, model(WID[i], a, b, cin, sub), lat);
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      dvin[i] = 1'b0;
    end
  endtask

  task automatic drain(input int i);
    @(negedge clk);
    dvin[i] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exp_q[i].size() == 0) return;
      @(negedge clk);
    end
    check($sformatf("d%0d_drain_left", i), 64'(exp_q[i].size()), 64'd0);
    exp_q[i].delete();
  endtask

  // ---------------- monitor ----------------
  bit          stall_prev [3];
  logic [63:0] held [3];

  initial begin
    exp_t t;
    for (int i = 0; i < 3; i++) stall_prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          stall_prev[i] = 1'b0;
          continue;
        end
        if (stall_prev[i])
          check($sformatf("d%0d_hold", i), {29'b0, mvld[i], mov[i], mco[i], mo[i]}, held[i]);
        if (mvld[i] && !ordy[i])
          check($sformatf("d%0d_stall_in_ready", i), 64'(mrdy[i]), 64'd0);
        if (mvld[i] && ordy[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("d%0d_spurious_out_valid", i), 64'(mvld[i]), 64'd0);
          end else begin
            t = exp_q[i].pop_front();
            check($sformatf("d%0d_result", i), {30'b0, mov[i], mco[i], mo[i]},
                  {30'b0, t.ov, t.co, t.res});
            if (t.lat)
              check($sformatf("d%0d_latency", i), 64'(cyc - t.acc), 64'(LAT[i]));
          end
        end
        stall_prev[i] = mvld[i] && !ordy[i];
        held[i]       = {29'b0, mvld[i], mov[i], mco[i], mo[i]};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      da[i] = '0; db[i] = '0; dcin[i] = 1'b0; dsub[i] = 1'b0; dvin[i] = 1'b0; dordy[i] = 1'b1;
    end
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(mvld[0]), 64'd0);
    check("rst_out", 64'(o16), 64'd0);
    check("rst_cout_ovf", {62'b0, mco[0], mov[0]}, 64'd0);
    check("rst_in_ready", 64'(mrdy[0]), 64'd1);
    // Inputs offered during reset must not be captured.
    da[0] = 32'h1111; db[0] = 32'h2222; dvin[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dvin[0] = 1'b0;
    idle(0, 6);

    // Directed add/sub vectors, back to back, with sub changing per transaction.
    issue(0, 32'hFFFF, 32'h0001, 0, 0, ex(0, 1, 32'h0000), 1);
    issue(0, 32'h7FFF, 32'h0001, 0, 0, ex(1, 0, 32'h8000), 1);
    issue(0, 32'h0005, 32'h0007, 1, 1, ex(0, 0, 32'hFFFE), 1);
    issue(0, 32'h8000, 32'h0001, 0, 1, ex(1, 1, 32'h7FFF), 1);
    issue(0, 32'h1234, 32'h4321, 1, 0, ex(0, 0, 32'h5556), 1);
    issue(0, 32'hFFFF, 32'hFFFF, 1, 0, ex(0, 1, 32'hFFFF), 1);
    issue(0, 32'h8000, 32'h8000, 0, 0, ex(1, 1, 32'h0000), 1);
    issue(0, 32'h0000, 32'h0000, 0, 1, ex(0, 1, 32'h0000), 1);
    issue(0, 32'h1234, 32'h1234, 0, 1, ex(0, 1, 32'h0000), 1);
    issue(0, 32'h7FFF, 32'hFFFF, 0, 1, ex(1, 0, 32'h8000), 1);
    issue(0, 32'h0FFF, 32'h0001, 0, 0, ex(0, 0, 32'h1000), 1);
    drain(0);

    // Bubbles between transactions.
    issue(0, 32'h00FF, 32'h0001, 0, 0, ex(0, 0, 32'h0100), 1);
    idle(0, 2);
    issue(0, 32'h0010, 32'h0020, 0, 1, ex(0, 0, 32'hFFF0), 1);
    drain(0);

    // Stall pattern on out_ready with a random back-to-back stream.
    pat_on = 1'b1;
    for (int k = 0; k < 8; k++) issue_rand(0, 0);
    drain(0);
    pat_on = 1'b0;
    idle(0, 2);

    // Three in flight, result held at the output, then reset mid-cycle.
    issue(0, 32'h0101, 32'h0202, 0, 0, ex(0, 0, 32'h0303), 0);
    issue(0, 32'h0404, 32'h0505, 0, 0, ex(0, 0, 32'h0909), 0);
    issue(0, 32'h0606, 32'h0707, 0, 0, ex(0, 0, 32'h0D0D), 0);
    @(negedge clk);
    dvin[0] = 1'b0;
    dordy[0] = 1'b0;
    @(negedge clk);
    #3;
    check("pre_rst_out_valid", 64'(mvld[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(mvld[0]), 64'd0);
    check("async_rst_out", 64'(o16), 64'd0);
    check("async_rst_cout_ovf", {62'b0, mco[0], mov[0]}, 64'd0);
    check("async_rst_in_ready", 64'(mrdy[0]), 64'd1);
    exp_q[0].delete();
    da[0] = 32'hAAAA; db[0] = 32'h5555; dvin[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dvin[0] = 1'b0;
    dordy[0] = 1'b1;
    idle(0, 8);
    issue(0, 32'h0001, 32'h0001, 0, 0, ex(0, 0, 32'h0002), 1);
    drain(0);

    // 32/8 random add/sub stream.
    for (int k = 0; k < 10; k++) issue_rand(1, 1);
    drain(1);

    // 8/8 single-stage: directed then random.
    issue(2, 32'hFF, 32'h01, 0, 0, ex(0, 1, 32'h00), 1);
    issue(2, 32'h7F, 32'h01, 0, 0, ex(1, 0, 32'h80), 1);
    issue(2, 32'h05, 32'h07, 1, 1, ex(0, 0, 32'hFE), 1);
    for (int k = 0; k < 10; k++) issue_rand(2, 1);
    drain(2);

    idle(0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
